// File: rtl/wb_gpio_in_if.sv
// -----------------------------------------------------------------------------
// wb_if: classic pipelined Wishbone bus bundle.
//   cyc, stb, we      : master -> slave cycle / strobe / write enable
//   adr[31:0]         : byte address
//   sel[3:0]          : byte-lane enables
//   dat_m[31:0]       : write data (master -> slave)
//   dat_s[31:0]       : read data (slave -> master)
//   ack, stall, err   : slave -> master handshake
// Clock and reset travel alongside the bus as separate ports of each agent.
// -----------------------------------------------------------------------------
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic        ack;
    logic        stall;
    logic        err;

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, stall, err
    );

    modport master (
        input  dat_s, ack, stall, err,
        output cyc, stb, we, adr, sel, dat_m
    );
endinterface

// File: rtl/wb_gpio_in.sv
// -----------------------------------------------------------------------------
// wb_gpio_in: Wishbone slave sampling external buttons/switches.
// Each input is synchronised (2 flops) and debounced; rising edges of the
// debounced value latch into a write-1-to-clear EDGE register, and irq is a
// registered level of |(EDGE & IRQ_EN).
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   wb       Wishbone slave (never stalls, never errors, 1-cycle ack)
//   gpio_in  raw asynchronous inputs, N bits
//   irq      level interrupt, registered
//
// Register map (adr[3:2], aliases every 16 bytes):
//   0x0 DATA   RO   debounced state
//   0x4 EDGE   W1C  latched rising edges
//   0x8 IRQ_EN RW   per-bit interrupt enable, byte-lane writes
//   0xC RAW    RO   synchronised, not debounced
// -----------------------------------------------------------------------------
module wb_gpio_in #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    wb_if.slave          wb,
    input  logic [N-1:0] gpio_in,
    output logic         irq
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_EDGE   = 2'd1;
    localparam logic [1:0] REG_IRQ_EN = 2'd2;
    localparam logic [1:0] REG_RAW    = 2'd3;

    // Zero-extend an N-bit register to the 32-bit bus.
    function automatic logic [31:0] zext(input logic [N-1:0] v);
        logic [31:0] r;
        r        = 32'd0;
        r[N-1:0] = v;
        return r;
    endfunction

    // Expand sel into a 32-bit per-bit byte-lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        m = 32'd0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{s[b]}};
        end
        return m;
    endfunction

    logic [N-1:0]  sync0;
    logic [N-1:0]  sync1;
    logic [N-1:0]  stable;
    logic [N-1:0]  stable_next;
    logic [N-1:0]  rise;
    logic [CW-1:0] cnt      [N];
    logic [CW-1:0] cnt_next [N];

    logic [N-1:0]  edge_reg;
    logic [N-1:0]  irq_en;
    logic [N-1:0]  edge_clr;
    logic [N-1:0]  irq_en_next;

    logic          accept;
    logic          wr;
    logic          rd;
    logic [31:0]   lanes;
    logic [31:0]   wdata_masked;
    logic [31:0]   rdata;
    logic          ack;
    logic [31:0]   dat_s;

    // Only adr[3:2] decodes; the remaining address bits are don't-care.
    logic unused_adr;
    assign unused_adr = ^{wb.adr[31:4], wb.adr[1:0]};

    assign accept       = wb.cyc & wb.stb;
    assign wr           = accept & wb.we;
    assign rd           = accept & ~wb.we;
    assign lanes        = lane_mask(wb.sel);
    assign wdata_masked = wb.dat_m & lanes;

    assign wb.ack   = ack;
    assign wb.dat_s = dat_s;
    assign wb.stall = 1'b0;
    assign wb.err   = 1'b0;

    // Two-flop synchroniser on every input bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            sync0 <= gpio_in;
            sync1 <= sync0;
        end
    end

    // Debouncer next state: the counter runs only while synced disagrees with
    // stable, and stable flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = cnt[i];
            if (sync1[i] == stable[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                stable_next[i] = ~stable[i];
                cnt_next[i]    = '0;
            end else begin
                cnt_next[i] = cnt[i] + CW'(1);
            end
        end
    end

    assign rise = stable_next & ~stable;

    // Debouncer state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable_next;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Write decode: W1C mask for EDGE and lane-merged IRQ_EN value.
    always_comb begin
        edge_clr    = '0;
        irq_en_next = irq_en;
        if (wr) begin
            case (wb.adr[3:2])
                REG_EDGE:   edge_clr    = wdata_masked[N-1:0];
                REG_IRQ_EN: irq_en_next = (irq_en & ~lanes[N-1:0]) | wdata_masked[N-1:0];
                default:    ;
            endcase
        end else begin
            edge_clr    = '0;
            irq_en_next = irq_en;
        end
    end

    // EDGE / IRQ_EN registers; a same-cycle rising edge beats the W1C clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_reg <= '0;
            irq_en   <= '0;
        end else begin
            edge_reg <= (edge_reg & ~edge_clr) | rise;
            irq_en   <= irq_en_next;
        end
    end

    // Registered interrupt level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_reg & irq_en);
        end
    end

    // Read data mux.
    always_comb begin
        rdata = 32'd0;
        case (wb.adr[3:2])
            REG_DATA:   rdata = zext(stable);
            REG_EDGE:   rdata = zext(edge_reg);
            REG_IRQ_EN: rdata = zext(irq_en);
            REG_RAW:    rdata = zext(sync1);
            default:    rdata = 32'd0;
        endcase
    end

    // Single-cycle ack per accepted request; dat_s is zero outside read acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            dat_s <= 32'd0;
        end else begin
            ack   <= accept;
            dat_s <= rd ? rdata : 32'd0;
        end
    end

endmodule
